// File: rtl/bp2_btb_fetch_predictor_pkg.sv
// Shared branch-predictor definitions: counter states, default table
// geometry and the PC field extractors used by fetch and by the PC pipe-down.
package mips_bp_pkg;

  localparam int BP_IDX_W = 6;
  localparam int BP_TAG_W = 24;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } cnt_state_t;

  // Move one step toward taken or not-taken; both ends hold.
  function automatic cnt_state_t sat_inc_dec(input cnt_state_t cnt, input logic taken);
    cnt_state_t nxt;
    nxt = cnt;
    if (taken && (cnt != ST)) begin
      nxt = cnt_state_t'(cnt + 2'd1);
    end else if (!taken && (cnt != SNT)) begin
      nxt = cnt_state_t'(cnt - 2'd1);
    end
    return nxt;
  endfunction

  // Table index: word address bits right above the byte offset.
  function automatic logic [31:0] bp_idx(input logic [31:0] pc, input int idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // Tag: the tag_w bits sitting directly above the index field.
  function automatic logic [31:0] bp_tag(input logic [31:0] pc, input int idx_w, input int tag_w);
    return (pc >> (idx_w + 2)) & ((32'd1 << tag_w) - 32'd1);
  endfunction

endpackage

// File: rtl/bp2_btb_fetch_predictor_if.sv
// Fetch lookup, M-stage resolution and statistics signals between the core
// (master) and the next-PC predictor (slave).
interface bp2_btb_fetch_predictor_if;

  logic        pc_f;
  logic [31:0] pc_f_w;

  logic [31:0] pc_f_addr;

  logic        is_branch_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic [31:0] npc_f;

  logic        upd_valid_m;
  logic [31:0] upd_pc_m;
  logic        upd_taken_m;
  logic [31:0] upd_target_m;
  logic        upd_pred_taken_m;
  logic [31:0] upd_pred_target_m;
  logic        mispred_m;
  logic [31:0] redirect_pc_m;

  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  modport master (
    output pc_f_addr, is_branch_f,
    output upd_valid_m, upd_pc_m, upd_taken_m, upd_target_m,
    output upd_pred_taken_m, upd_pred_target_m,
    input  pred_taken_f, pred_target_f, npc_f,
    input  mispred_m, redirect_pc_m, stat_branches, stat_mispred
  );

  modport slave (
    input  pc_f_addr, is_branch_f,
    input  upd_valid_m, upd_pc_m, upd_taken_m, upd_target_m,
    input  upd_pred_taken_m, upd_pred_target_m,
    output pred_taken_f, pred_target_f, npc_f,
    output mispred_m, redirect_pc_m, stat_branches, stat_mispred
  );

endinterface

// File: rtl/bp2_btb_fetch_predictor_btb_table.sv
// Direct-mapped storage for the predictor: BTB valid/tag/target arrays plus
// the untagged 2-bit direction counters. One combinational read port and one
// registered write port, so a same-index read sees the old contents.
module bp_btb_table
  import mips_bp_pkg::*;
#(
  parameter int         IDX_W    = BP_IDX_W,
  parameter int         TAG_W    = BP_TAG_W,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_target,
  output cnt_state_t       rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_target
);

  localparam int DEPTH = 1 << IDX_W;

  logic             valid_q  [DEPTH];
  logic             valid_d  [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [TAG_W-1:0] tag_d    [DEPTH];
  logic [31:0]      target_q [DEPTH];
  logic [31:0]      target_d [DEPTH];
  cnt_state_t       cnt_q    [DEPTH];
  cnt_state_t       cnt_d    [DEPTH];

  assign rd_valid  = valid_q[rd_idx];
  assign rd_tag    = tag_q[rd_idx];
  assign rd_target = target_q[rd_idx];
  assign rd_cnt    = cnt_q[rd_idx];

  // Counter always trains on a resolved branch; BTB only allocates on taken.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (wr_en) begin
      cnt_d[wr_idx] = sat_inc_dec(cnt_q[wr_idx], wr_taken);
      if (wr_taken) begin
        valid_d[wr_idx]  = 1'b1;
        tag_d[wr_idx]    = wr_tag;
        target_d[wr_idx] = wr_target;
      end
    end
  end

  // Table state; reset drops every BTB entry and returns counters to their initial value.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= cnt_state_t'(CNT_INIT);
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/bp2_btb_fetch_predictor.sv
// Fetch-stage next-PC predictor: combinational lookup on the fetch PC,
// combinational mispredict detection in M, table training and saturating
// statistics on every resolved branch.
module bp2_btb_fetch_predictor
  import mips_bp_pkg::*;
#(
  parameter int         IDX_W    = BP_IDX_W,
  parameter int         TAG_W    = BP_TAG_W,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input logic                      CLK,
  input logic                      RSTn,
  bp2_btb_fetch_predictor_if.slave bp
);

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] pc_tag;
  logic [TAG_W-1:0] wr_tag;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_target;
  cnt_state_t       rd_cnt;

  logic             hit;
  logic             pred_taken;
  logic [31:0]      pc_plus4;
  logic [31:0]      pred_target;
  logic             mispred;
  logic [31:0]      redirect_pc;
  logic [31:0]      npc;

  logic [31:0]      stat_branches_q;
  logic [31:0]      stat_branches_d;
  logic [31:0]      stat_mispred_q;
  logic [31:0]      stat_mispred_d;

  bp_btb_table #(
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W),
    .CNT_INIT (CNT_INIT)
  ) u_table (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .rd_idx    (rd_idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_target (rd_target),
    .rd_cnt    (rd_cnt),
    .wr_en     (bp.upd_valid_m),
    .wr_idx    (wr_idx),
    .wr_taken  (bp.upd_taken_m),
    .wr_tag    (wr_tag),
    .wr_target (bp.upd_target_m)
  );

  // Fetch lookup; a redirect from M overrides whatever fetch would predict.
  always_comb begin
    rd_idx      = IDX_W'(bp_idx(bp.pc_f_addr, IDX_W));
    pc_tag      = TAG_W'(bp_tag(bp.pc_f_addr, IDX_W, TAG_W));
    pc_plus4    = bp.pc_f_addr + 32'd4;
    hit         = rd_valid && (rd_tag == pc_tag);
    pred_taken  = bp.is_branch_f && hit && rd_cnt[1];
    pred_target = hit ? rd_target : pc_plus4;
    npc         = mispred ? redirect_pc : (pred_taken ? pred_target : pc_plus4);
  end

  // M-stage resolution; held quiet while reset is asserted.
  always_comb begin
    wr_idx      = IDX_W'(bp_idx(bp.upd_pc_m, IDX_W));
    wr_tag      = TAG_W'(bp_tag(bp.upd_pc_m, IDX_W, TAG_W));
    redirect_pc = bp.upd_taken_m ? bp.upd_target_m : (bp.upd_pc_m + 32'd4);
    mispred     = RSTn && bp.upd_valid_m &&
                  ((bp.upd_taken_m != bp.upd_pred_taken_m) ||
                   (bp.upd_taken_m && (bp.upd_pred_target_m != bp.upd_target_m)));
  end

  // Statistic next-state; both counters stick at all-ones instead of wrapping.
  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_mispred_d  = stat_mispred_q;
    if (bp.upd_valid_m && (stat_branches_q != 32'hFFFF_FFFF)) begin
      stat_branches_d = stat_branches_q + 32'd1;
    end
    if (mispred && (stat_mispred_q != 32'hFFFF_FFFF)) begin
      stat_mispred_d = stat_mispred_q + 32'd1;
    end
  end

  // Statistic registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign bp.pred_taken_f  = pred_taken;
  assign bp.pred_target_f = pred_target;
  assign bp.npc_f         = npc;
  assign bp.mispred_m     = mispred;
  assign bp.redirect_pc_m = redirect_pc;
  assign bp.stat_branches = stat_branches_q;
  assign bp.stat_mispred  = stat_mispred_q;

endmodule

// File: tb/tb_bp2_btb_fetch_predictor.sv
// Directed bench for the fetch next-PC predictor: reset behaviour, training,
// aliasing, read-old on same-cycle update, statistic saturation, async reset.
module tb_bp2_btb_fetch_predictor;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic        tkSeq     [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        predSeq   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic        mpSeq     [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] cntBefore [7] = '{32'd2, 32'd3, 32'd3, 32'd3, 32'd2, 32'd1, 32'd0};

  bp2_btb_fetch_predictor_if bp_if ();

  bp2_btb_fetch_predictor dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bp   (bp_if)
  );

  // 10 ns clock.
  always #5 CLK = ~CLK;

  // Drive one cycle of inputs just after the falling edge.
  task automatic applyStimulus(input logic [31:0] pc, input logic isBr, input logic uv,
                               input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                               input logic upt, input logic [31:0] uptgt);
    @(negedge CLK);
    bp_if.pc_f_addr         = pc;
    bp_if.is_branch_f       = isBr;
    bp_if.upd_valid_m       = uv;
    bp_if.upd_pc_m          = upc;
    bp_if.upd_taken_m       = ut;
    bp_if.upd_target_m      = utgt;
    bp_if.upd_pred_taken_m  = upt;
    bp_if.upd_pred_target_m = uptgt;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    checkOutput(tag, {31'b0, observed}, {31'b0, expected});
  endtask

  function automatic logic [31:0] cnt16();
    return 32'(dut.u_table.cnt_q[16]);
  endfunction

  // Fail-safe so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence.
  initial begin
    bp_if.pc_f_addr = 32'h0; bp_if.is_branch_f = 1'b0; bp_if.upd_valid_m = 1'b0;
    bp_if.upd_pc_m = 32'h0; bp_if.upd_taken_m = 1'b0; bp_if.upd_target_m = 32'h0;
    bp_if.upd_pred_taken_m = 1'b0; bp_if.upd_pred_target_m = 32'h0;

    // In reset an update that would mispredict is suppressed and discarded.
    applyStimulus(32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    checkFlag("rst_mispred", bp_if.mispred_m, 1'b0);
    checkOutput("rst_npc", bp_if.npc_f, 32'h44);
    checkOutput("rst_cnt", cnt16(), 32'd1);
    applyStimulus(32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("rst_pred_target", bp_if.pred_target_f, 32'h44);
    RSTn = 1'b1;

    // Test 1: cold lookup.
    applyStimulus(32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkFlag("t1_pred_taken", bp_if.pred_taken_f, 1'b0);
    checkOutput("t1_npc", bp_if.npc_f, 32'h44);
    checkOutput("t1_branches", bp_if.stat_branches, 32'd0);
    checkOutput("t1_mispred_cnt", bp_if.stat_mispred, 32'd0);

    // Test 2: first taken resolution installs the entry.
    applyStimulus(32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    checkFlag("t2_mispred", bp_if.mispred_m, 1'b1);
    checkOutput("t2_redirect", bp_if.redirect_pc_m, 32'h80);
    checkOutput("t2_npc_redirect", bp_if.npc_f, 32'h80);
    checkFlag("t2_pred_old", bp_if.pred_taken_f, 1'b0);
    applyStimulus(32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkFlag("t2_pred_taken", bp_if.pred_taken_f, 1'b1);
    checkOutput("t2_pred_target", bp_if.pred_target_f, 32'h80);
    checkOutput("t2_npc", bp_if.npc_f, 32'h80);
    checkOutput("t2_cnt", cnt16(), 32'd2);
    checkOutput("t2_branches", bp_if.stat_branches, 32'd1);
    checkOutput("t2_mispred_cnt", bp_if.stat_mispred, 32'd1);

    // Test 3: saturate up, then walk down to strongly not-taken.
    for (int k = 0; k < 7; k++) begin
      applyStimulus(32'h40, 1'b1, 1'b1, 32'h40, tkSeq[k], 32'h80, predSeq[k], 32'h80);
      checkOutput($sformatf("t3_cnt_%0d", k), cnt16(), cntBefore[k]);
      checkFlag($sformatf("t3_pred_%0d", k), bp_if.pred_taken_f, predSeq[k]);
      checkFlag($sformatf("t3_mispred_%0d", k), bp_if.mispred_m, mpSeq[k]);
    end
    applyStimulus(32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("t3_cnt_end", cnt16(), 32'd0);
    checkFlag("t3_pred_end", bp_if.pred_taken_f, 1'b0);
    checkOutput("t3_btb_kept", bp_if.pred_target_f, 32'h80);
    checkOutput("t3_branches", bp_if.stat_branches, 32'd8);
    checkOutput("t3_mispred_cnt", bp_if.stat_mispred, 32'd3);

    // Test 4: conflicting tag evicts the entry at index 16.
    applyStimulus(32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    checkOutput("t4_redirect_a", bp_if.redirect_pc_m, 32'h80);
    applyStimulus(32'h140, 1'b1, 1'b1, 32'h140, 1'b1, 32'h200, 1'b0, 32'h144);
    checkFlag("t4_mispred_b", bp_if.mispred_m, 1'b1);
    applyStimulus(32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkFlag("t4_miss_pred", bp_if.pred_taken_f, 1'b0);
    checkOutput("t4_miss_target", bp_if.pred_target_f, 32'h44);
    checkOutput("t4_miss_npc", bp_if.npc_f, 32'h44);
    applyStimulus(32'h140, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkFlag("t4_hit_pred", bp_if.pred_taken_f, 1'b1);
    checkOutput("t4_hit_npc", bp_if.npc_f, 32'h200);
    checkOutput("t4_branches", bp_if.stat_branches, 32'd10);
    checkOutput("t4_mispred_cnt", bp_if.stat_mispred, 32'd5);

    // Test 5: reinstall 0x40, bring counter to WNT, then same-cycle lookup+update.
    applyStimulus(32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    applyStimulus(32'h40, 1'b1, 1'b1, 32'h40, 1'b0, 32'h80, 1'b0, 32'h44);
    checkFlag("t5_nt_no_mispred", bp_if.mispred_m, 1'b0);
    applyStimulus(32'h40, 1'b1, 1'b1, 32'h40, 1'b0, 32'h80, 1'b0, 32'h44);
    applyStimulus(32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h90);
    checkOutput("t5_cnt_wnt", cnt16(), 32'd1);
    checkFlag("t5_pred_old", bp_if.pred_taken_f, 1'b0);
    checkOutput("t5_target_hit", bp_if.pred_target_f, 32'h80);
    checkFlag("t5_target_mispred", bp_if.mispred_m, 1'b1);
    checkOutput("t5_redirect", bp_if.redirect_pc_m, 32'h80);
    applyStimulus(32'h40, 1'b1, 1'b0, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    checkFlag("t5_pred_new", bp_if.pred_taken_f, 1'b1);
    checkFlag("t5_idle_mispred", bp_if.mispred_m, 1'b0);
    checkOutput("t5_npc", bp_if.npc_f, 32'h80);
    checkOutput("t5_branches", bp_if.stat_branches, 32'd14);
    checkOutput("t5_mispred_cnt", bp_if.stat_mispred, 32'd7);
    applyStimulus(32'h40, 1'b0, 1'b0, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    checkFlag("t5_not_branch", bp_if.pred_taken_f, 1'b0);
    checkOutput("t5_idle_branches", bp_if.stat_branches, 32'd14);

    // Test 6: mispredict statistic saturation.
    applyStimulus(32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    force dut.stat_mispred_q = 32'hFFFF_FFFE;
    @(posedge CLK);
    #1;
    release dut.stat_mispred_q;
    checkOutput("t6_preload", bp_if.stat_mispred, 32'hFFFF_FFFE);
    applyStimulus(32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    checkFlag("t6_mispred_1", bp_if.mispred_m, 1'b1);
    applyStimulus(32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    checkOutput("t6_sat_1", bp_if.stat_mispred, 32'hFFFF_FFFF);
    applyStimulus(32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    checkOutput("t6_sat_2", bp_if.stat_mispred, 32'hFFFF_FFFF);
    applyStimulus(32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    checkOutput("t6_sat_3", bp_if.stat_mispred, 32'hFFFF_FFFF);
    checkOutput("t6_branches", bp_if.stat_branches, 32'd17);

    // Async reset between clock edges with an update still applied.
    #2;
    RSTn = 1'b0;
    #1;
    checkOutput("t6_rst_branches", bp_if.stat_branches, 32'd0);
    checkOutput("t6_rst_mispred_cnt", bp_if.stat_mispred, 32'd0);
    checkFlag("t6_rst_mispred", bp_if.mispred_m, 1'b0);
    checkOutput("t6_rst_npc", bp_if.npc_f, 32'h44);
    checkOutput("t6_rst_cnt", cnt16(), 32'd1);
    @(posedge CLK);
    #1;
    checkOutput("t6_rst_hold_target", bp_if.pred_target_f, 32'h44);
    RSTn = 1'b1;
    applyStimulus(32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("t6_post_target", bp_if.pred_target_f, 32'h44);
    checkFlag("t6_post_pred", bp_if.pred_taken_f, 1'b0);
    checkOutput("t6_post_branches", bp_if.stat_branches, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp2_btb_fetch_predictor.md
Name: bp2_btb_fetch_predictor

Overview:
- Fetch-stage next-PC predictor that feeds the PC register of the pipelined MIPS core.
- Combines a 2-bit saturating-counter direction table with a tagged, direct-mapped branch target buffer.
- Prediction is combinational from the current PC.
- Branch outcomes resolved in the Memory stage update the tables and drive the redirect/flush decision back to fetch.

Parameters:
- IDX_W, 6, index width; table depth = 2**IDX_W entries, index = PC[IDX_W+1:2]
- TAG_W, 24, BTB tag width; tag = PC[IDX_W+2+TAG_W-1 : IDX_W+2]; IDX_W+2+TAG_W must be <= 32
- CNT_INIT, 2'b01, counter value after reset (weakly not-taken)

Ports:
- CLK  in  1  clock, rising edge
- RSTn  in  1  asynchronous active-low reset
- pc_f  in  32  current fetch PC
- is_branch_f  in  1  fetched instruction is beq/bne (decoded from Instr[31:26])
- pred_taken_f  out  1  predicted direction for pc_f
- pred_target_f  out  32  predicted target (BTB entry target on hit, else pc_f+4)
- npc_f  out  32  next PC to load into the PC register
- upd_valid_m  in  1  a branch is resolved in the M stage this cycle
- upd_pc_m  in  32  address of the resolved branch
- upd_taken_m  in  1  actual direction
- upd_target_m  in  32  actual taken target (PCBranch_M)
- upd_pred_taken_m  in  1  direction predicted for this branch at fetch, piped down
- upd_pred_target_m  in  32  target predicted at fetch, piped down
- mispred_m  out  1  redirect/flush request
- redirect_pc_m  out  32  correct next PC on mispredict
- stat_branches  out  32  resolved-branch count
- stat_mispred  out  32  mispredict count

Behaviour:
- Reset, asynchronous, RSTn=0:
  - all counters = CNT_INIT; all BTB valid bits = 0; stat counters = 0.
  - Outputs follow combinationally: pred_taken_f=0, pred_target_f=pc_f+4, npc_f=pc_f+4, mispred_m=0.
  - Reset asserted mid-operation discards any in-flight update that cycle.
- Lookup, 0-cycle latency, combinational:
  - hit = valid[idx] && tag[idx]==pc_f tag bits.
  - pred_taken_f = is_branch_f && hit && cnt[idx][1].
  - pred_target_f = hit ? target[idx] : pc_f+4.
  - npc_f = mispred_m ? redirect_pc_m : (pred_taken_f ? pred_target_f : pc_f+4). A redirect always wins over the fetch prediction.
- Resolution, combinational in M:
  - mispred_m = upd_valid_m && ((upd_taken_m != upd_pred_taken_m) || (upd_taken_m && upd_pred_target_m != upd_target_m)).
  - redirect_pc_m = upd_taken_m ? upd_target_m : upd_pc_m+4.
  - mispred_m=0 whenever upd_valid_m=0.
- Update, registered, visible to lookups from the next cycle, only when upd_valid_m=1:
  - Counter at idx(upd_pc_m): increments if taken, decrements if not, saturating at 3 and 0.
  - If taken, the BTB entry is written: valid=1, tag, target=upd_target_m. This overwrites any conflicting entry.
  - If not taken, the BTB entry is left unchanged; there is no allocation on not-taken.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update value (read-old).
- Statistics:
  - stat_branches increments on each upd_valid_m; stat_mispred increments on each mispred_m.
  - Both saturate at 32'hFFFF_FFFF and never wrap.
- The counter state machine per entry is SNT(0) ↔ WNT(1) ↔ WT(2) ↔ ST(3). T moves right, NT moves left, and the ends hold.
- Counters are untagged; aliasing between branches that share an index is accepted.
- PC bits [1:0] are ignored for both index and tag.

Decomposition:
- Shared package mips_bp_pkg holds:
  - cnt_state_t enum (SNT, WNT, WT, ST)
  - default IDX_W/TAG_W constants
  - function sat_inc_dec(cnt, taken)
  - function bp_idx/bp_tag extractors, reused by the core's PC pipe-down logic
- One sub-module: bp_btb_table. It holds the valid/tag/target arrays plus the counter array with async reset, one read port and one write port. The top level holds lookup/resolve muxing and statistics.

Test Plan:
1. Reset, then pc_f=0x40, is_branch_f=1 -> pred_taken_f=0, npc_f=0x44; both stats = 0.
2. Update {pc=0x40, taken=1, target=0x80, pred_taken=0} -> mispred_m=1, redirect_pc_m=0x80. Next cycle lookup 0x40 -> hit, counter=WT, pred_taken_f=1, npc_f=0x80.
3. Three taken updates at 0x40, then four not-taken -> counter sequence 2,3,3,3,2,1,0. pred_taken_f flips to 0 after the second not-taken. The BTB entry stays valid.
4. Taken update at 0x40 (target 0x80), then taken update at 0x140 (same index, different tag, target 0x200) -> lookup 0x40 misses, npc_f=0x44; lookup 0x140 hits with 0x200.
5. Same cycle: lookup 0x40 and taken update at 0x40 with the counter at WNT -> pred_taken_f=0 that cycle, 1 the next cycle. With upd_pred_taken=1 and upd_pred_target=0x90 vs actual 0x80 -> mispred_m=1 on the target mismatch.
6. Force stat_mispred to 32'hFFFF_FFFE, then issue 3 mispredicts -> the count holds at 32'hFFFF_FFFF. Pulse RSTn=0 asynchronously mid-update -> all tables and stats clear immediately.
